// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: the queue entry layout and the fetch FSM states.
package fetch_pkg;

   localparam int FETCH_PC_W     = 32;
   localparam int FETCH_BUNDLE_W = 128;

   typedef struct packed {
      logic [FETCH_PC_W-1:0]     pc;
      logic [FETCH_BUNDLE_W-1:0] bundle;
   } fetch_entry_t;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_queue2.sv
// Two-entry FIFO of fetch entries. Slot 0 is always the head; clear dominates push.
module fetch_queue2
   import fetch_pkg::*;
#(
   parameter logic [FETCH_PC_W-1:0] RST_PC = '0
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  fetch_entry_t din,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t slot0, slot1;
   logic         pop_ok;

   assign pop_ok = pop && (count != 2'd0);
   assign head   = slot0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slot0 <= '{pc: RST_PC, bundle: '0};
         slot1 <= '0;
         count <= 2'd0;
      end else if (clear) begin
         count <= 2'd0;
      end else begin
         unique case ({push, pop_ok})
            2'b10: begin
               if (count == 2'd0) slot0 <= din;
               else               slot1 <= din;
               if (count != 2'd2) count <= count + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Occupancy is unchanged; the new entry lands behind whatever remains.
               if (count == 2'd1) slot0 <= din;
               else begin
                  slot0 <= slot1;
                  slot1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fetch_redirect.sv
// Fetch PC, 1-cycle imem issue, 2-entry decode queue and branch redirect handling.
// Optional perf counters under `FETCH_REDIRECT_PERF_EN. PC_W/BUNDLE_W must match fetch_pkg.
module fetch_redirect
   import fetch_pkg::*;
#(
   parameter int               PC_W     = FETCH_PC_W,
   parameter int               BUNDLE_W = FETCH_BUNDLE_W,
   parameter logic [PC_W-1:0]  RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                npc_enn,
   input  logic [PC_W-1:0]     npc_target,
   input  logic                stall,
   output logic                imem_en,
   output logic [PC_W-1:0]     imem_addr,
   input  logic [BUNDLE_W-1:0] imem_rdata,
   output logic                dec_valid,
   output logic [PC_W-1:0]     dec_pc,
   output logic [BUNDLE_W-1:0] dec_bundle
`ifdef FETCH_REDIRECT_PERF_EN
   ,
   output logic [31:0]         redirect_cnt,
   output logic [31:0]         squash_cnt
`endif
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] fetch_pc;
   logic [PC_W-1:0] inflight_pc;
   logic            inflight;
   logic            kill;

   logic            q_push, q_pop;
   logic [1:0]      q_count;
   logic [2:0]      q_occ;
   fetch_entry_t    q_din, q_head;

   assign q_din   = '{pc: inflight_pc, bundle: imem_rdata};
   assign q_push  = inflight && !kill && !npc_enn;
   assign q_pop   = dec_valid && !stall && !npc_enn;
   // Occupancy once this cycle's in-flight response lands and any pop retires.
   assign q_occ   = {1'b0, q_count} + {2'b0, inflight} - {2'b0, q_pop};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= BOOT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      imem_en = 1'b0;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            state_d = RUN;
            imem_en = !npc_enn && (q_occ < 3'd2);
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= RESET_PC;
         kill        <= 1'b0;
      end else begin
         if (npc_enn)      fetch_pc <= npc_target;
         else if (imem_en) fetch_pc <= fetch_pc + 1'b1;
         inflight    <= imem_en;
         inflight_pc <= fetch_pc;
         kill        <= npc_enn;
      end
   end

   fetch_queue2 #(.RST_PC(RESET_PC)) u_queue (
      .clk   (clk),
      .rstn  (rstn),
      .push  (q_push),
      .pop   (q_pop),
      .clear (npc_enn),
      .din   (q_din),
      .head  (q_head),
      .count (q_count)
   );

   assign imem_addr  = fetch_pc;
   assign dec_valid  = (q_count != 2'd0);
   assign dec_pc     = q_head.pc;
   assign dec_bundle = q_head.bundle;

`ifdef FETCH_REDIRECT_PERF_EN
   logic [32:0] sq_sum;
   assign sq_sum = {1'b0, squash_cnt} + {31'b0, q_count} + {32'b0, inflight && !kill};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         redirect_cnt <= '0;
         squash_cnt   <= '0;
      end else if (npc_enn) begin
         if (redirect_cnt != '1) redirect_cnt <= redirect_cnt + 32'd1;
         squash_cnt <= sq_sum[32] ? '1 : sq_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect: boot, stall/backpressure, redirects, PC wrap, async reset.
module tb_fetch_redirect;

   logic         clk = 1'b0;
   logic         rstn = 1'b1;
   logic         npc_enn = 1'b0;
   logic [31:0]  npc_target = '0;
   logic         stall = 1'b0;
   logic         imem_en;
   logic [31:0]  imem_addr;
   logic [127:0] imem_rdata = '0;
   logic         dec_valid;
   logic [31:0]  dec_pc;
   logic [127:0] dec_bundle;
`ifdef FETCH_REDIRECT_PERF_EN
   logic [31:0]  redirect_cnt, squash_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int ovf    = 0;
   logic [31:0]  got_pc[$];
   logic [127:0] got_bd[$];

   fetch_redirect dut (
      .clk        (clk),
      .rstn       (rstn),
      .npc_enn    (npc_enn),
      .npc_target (npc_target),
      .stall      (stall),
      .imem_en    (imem_en),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .dec_valid  (dec_valid),
      .dec_pc     (dec_pc),
      .dec_bundle (dec_bundle)
`ifdef FETCH_REDIRECT_PERF_EN
      ,
      .redirect_cnt (redirect_cnt),
      .squash_cnt   (squash_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] bundle_of(input logic [31:0] a);
      return {96'h0, a ^ 32'h0000_00A5};
   endfunction

   // Instruction memory: one-cycle read latency, not affected by reset.
   always @(posedge clk) if (imem_en) imem_rdata <= bundle_of(imem_addr);

   always @(posedge clk) begin
      if (rstn && dec_valid && !stall && !npc_enn) begin
         got_pc.push_back(dec_pc);
         got_bd.push_back(dec_bundle);
      end
      if (rstn && dut.q_push && dut.q_count == 2'd2 && !dut.q_pop) ovf++;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   logic [31:0] exp_pops [5];

   initial begin
      exp_pops = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h20};

      // Reset
      #1 rstn = 1'b0;
      tick(); tick();
      chk("rst_en", imem_en, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_valid", dec_valid, 0);
      chk("rst_pc", dec_pc, 0);
      chk("rst_bundle", dec_bundle, 0);
      rstn = 1'b1;                                   // cycle 0
      #1 chk("boot_en", imem_en, 0);
      tick(); chk("c1_en", imem_en, 1); chk("c1_addr", imem_addr, 0); chk("c1_valid", dec_valid, 0);
      tick(); chk("c2_valid", dec_valid, 0); chk("c2_addr", imem_addr, 1);
      tick(); chk("c3_valid", dec_valid, 1); chk("c3_pc", dec_pc, 0); chk("c3_bundle", dec_bundle, bundle_of(0));

      // Stall for 5 cycles from cycle 4
      tick(); chk("c4_pc", dec_pc, 1);
      stall = 1'b1;
      #1 chk("stall_en", imem_en, 0);
      for (int i = 0; i < 4; i++) begin
         tick(); chk("stall_full_en", imem_en, 0); chk("stall_hold_pc", dec_pc, 1);
      end
      stall = 1'b0;                                  // cycle 9
      #1 chk("rel_en", imem_en, 1); chk("rel_addr", imem_addr, 3);
      tick(); chk("c10_pc", dec_pc, 2); chk("c10_valid", dec_valid, 1);
      tick(); chk("c11_pc", dec_pc, 3); chk("c11_valid", dec_valid, 1);
      tick(); chk("c12_pc", dec_pc, 4);
      stall = 1'b1;
      tick(); chk("c13_pc", dec_pc, 4); chk("c13_full_en", imem_en, 0);

      // Redirect to 0x40 with two entries queued
      npc_enn = 1'b1; npc_target = 32'h40;
      #1 chk("redir_en", imem_en, 0);
      tick(); npc_enn = 1'b0; stall = 1'b0;
      #1 chk("t1_valid", dec_valid, 0); chk("t1_en", imem_en, 1); chk("t1_addr", imem_addr, 32'h40);
`ifdef FETCH_REDIRECT_PERF_EN
      chk("redir_cnt1", redirect_cnt, 1); chk("squash1", squash_cnt, 2);
`endif
      tick(); chk("t2_valid", dec_valid, 0);
      tick(); chk("t3_valid", dec_valid, 1); chk("t3_pc", dec_pc, 32'h40); chk("t3_bundle", dec_bundle, bundle_of(32'h40));

      // Back-to-back redirects 0x10 then 0x20
      npc_enn = 1'b1; npc_target = 32'h10;
      tick(); npc_target = 32'h20;
      tick(); npc_enn = 1'b0;
      #1 chk("b2b_valid", dec_valid, 0); chk("b2b_addr", imem_addr, 32'h20);
`ifdef FETCH_REDIRECT_PERF_EN
      chk("redir_cnt3", redirect_cnt, 3); chk("squash3", squash_cnt, 4);
`endif
      tick(); chk("b2b_t2_valid", dec_valid, 0);
      tick(); chk("b2b_t3_pc", dec_pc, 32'h20); chk("b2b_t3_valid", dec_valid, 1);
      tick(); chk("b2b_t4_pc", dec_pc, 32'h21);

      chk("pop_count", got_pc.size(), 5);
      for (int i = 0; i < 5 && i < got_pc.size(); i++) begin
         chk("pop_pc", got_pc[i], exp_pops[i]);
         chk("pop_bundle", got_bd[i], bundle_of(exp_pops[i]));
      end

      // PC wrap
      npc_enn = 1'b1; npc_target = 32'hFFFF_FFFF;
      tick(); npc_enn = 1'b0;
`ifdef FETCH_REDIRECT_PERF_EN
      #1 chk("redir_cnt4", redirect_cnt, 4); chk("squash4", squash_cnt, 6);
`endif
      tick();
      tick(); chk("wrap_pc0", dec_pc, 32'hFFFF_FFFF); chk("wrap_v0", dec_valid, 1);
      tick(); chk("wrap_pc1", dec_pc, 0); chk("wrap_v1", dec_valid, 1);
      tick(); chk("wrap_pc2", dec_pc, 1); chk("wrap_v2", dec_valid, 1);
      chk("pre_rst_en", imem_en, 1);

      // Asynchronous reset mid-stream
      #2 rstn = 1'b0;
      #1 chk("arst_en", imem_en, 0); chk("arst_addr", imem_addr, 0);
      chk("arst_valid", dec_valid, 0); chk("arst_pc", dec_pc, 0); chk("arst_bundle", dec_bundle, 0);
`ifdef FETCH_REDIRECT_PERF_EN
      chk("arst_redir", redirect_cnt, 0); chk("arst_squash", squash_cnt, 0);
`endif
      tick(); rstn = 1'b1;
      #1 chk("re_boot_en", imem_en, 0);
      tick(); chk("re_c1_en", imem_en, 1); chk("re_c1_addr", imem_addr, 0); chk("re_c1_valid", dec_valid, 0);
      tick(); chk("re_c2_valid", dec_valid, 0);
      tick(); chk("re_c3_valid", dec_valid, 1); chk("re_c3_pc", dec_pc, 0); chk("re_c3_bundle", dec_bundle, bundle_of(0));

      chk("no_overflow", ovf, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
